inst_fetch_queue: RTL

Instruction fetch queue between the third fetch stage and decode. Each cycle it accepts up to two predecoded, prediction-annotated instruction entries from the fetch pipeline registers. It buffers them in program order in a circular FIFO and presents up to two entries per cycle to decode. It decouples front-end stalls from back-end stalls and is cleared by a back-end flush.

---
 rtl/inst_fetch_queue.sv | 85 ++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Dual-entry instruction fetch queue between fetch stage 3 and decode.
// Circular buffer with compacted two-wide enqueue and in-order two-wide dequeue.
module inst_fetch_queue #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq0_valid,
  input  logic [DATA_W-1:0]          enq0_data,
  input  logic                       enq1_valid,
  input  logic [DATA_W-1:0]          enq1_data,
  output logic                       enq_ready,
  output logic                       deq0_valid,
  output logic [DATA_W-1:0]          deq0_data,
  output logic                       deq1_valid,
  output logic [DATA_W-1:0]          deq1_data,
  input  logic                       deq0_ready,
  input  logic                       deq1_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [AW-1:0]     head_p1;
  logic [AW-1:0]     tail_p1;
  logic [AW-1:0]     wr1_idx;
  logic [1:0]        n_enq;
  logic [1:0]        n_deq;
  logic              do_enq;

  assign head_p1 = head + 1'b1;
  assign tail_p1 = tail + 1'b1;

  // Registered-only ready: room for a full pair, regardless of this cycle's dequeue.
  assign enq_ready  = (count <= CW'(DEPTH - 2));
  assign deq0_valid = (count != '0);
  assign deq1_valid = (count > CW'(1));
  assign deq0_data  = mem[head];
  assign deq1_data  = mem[head_p1];

  assign do_enq  = enq_ready && !flush;
  assign wr1_idx = enq0_valid ? tail_p1 : tail;

  always_comb begin
    n_enq = 2'd0;
    n_deq = 2'd0;
    if (enq_ready)
      n_enq = {1'b0, enq0_valid} + {1'b0, enq1_valid};
    if (deq0_ready && deq0_valid)
      n_deq = (deq1_ready && deq1_valid) ? 2'd2 : 2'd1;
  end

  // Storage is never cleared; validity is tracked purely by head/count.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      if (enq0_valid)
        mem[tail] <= enq0_data;
      if (enq1_valid)
        mem[wr1_idx] <= enq1_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_deq);
      tail  <= tail + AW'(n_enq);
      count <= count + CW'(n_enq) - CW'(n_deq);
    end
  end

endmodule
